// File: rtl/fpu_op_scheduler_if.sv
// Request/response/FPU-side signal bundle for fpu_op_scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface fpu_op_scheduler_if;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [7:0]  i_req_op;
  logic [63:0] i_req_a;
  logic [63:0] i_req_b;
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready;
  logic [31:0] o_rsp_c;
  logic        o_rsp_err;
  logic        o_fpu_start;
  logic [3:0]  o_fpu_op;
  logic [31:0] o_fpu_a;
  logic [31:0] o_fpu_b;
  logic [31:0] i_fpu_c;
  logic        o_busy;
  logic [15:0] o_op_count;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready, i_fpu_c,
    output o_req_ready, o_rsp_valid, o_rsp_c, o_rsp_err,
           o_fpu_start, o_fpu_op, o_fpu_a, o_fpu_b, o_busy, o_op_count
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready, i_fpu_c,
    input  o_req_ready, o_rsp_valid, o_rsp_c, o_rsp_err,
           o_fpu_start, o_fpu_op, o_fpu_a, o_fpu_b, o_busy, o_op_count
  );
endinterface

// File: rtl/fpu_op_scheduler.sv
// Round-robin scheduler sharing one fixed-latency, non-pipelined FPU between two requesters.
// Unsupported opcodes are answered directly with NAN_VAL and an error flag.
module fpu_op_scheduler #(
  parameter int unsigned LATENCY = 3,
  parameter logic [15:0] OP_MASK = 16'h0002,
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input logic               i_clk,
  input logic               i_reset_n,
  fpu_op_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      rsp_c_q, rsp_c_d;
  logic             rsp_err_q, rsp_err_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             fpu_start_q, fpu_start_d;
  logic             busy_q, busy_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             gnt;
  logic             gnt_vld;
  logic [3:0]       req_op_sel;
  logic [31:0]      req_a_sel;
  logic [31:0]      req_b_sel;

  // Round-robin arbiter: on contention the requester not granted last time wins
  always_comb begin
    gnt_vld = |bus.i_req_valid;
    if (bus.i_req_valid == 2'b11) gnt = ~last_grant_q;
    else                          gnt = bus.i_req_valid[1];
    req_op_sel = gnt ? bus.i_req_op[7:4]  : bus.i_req_op[3:0];
    req_a_sel  = gnt ? bus.i_req_a[63:32] : bus.i_req_a[31:0];
    req_b_sel  = gnt ? bus.i_req_b[63:32] : bus.i_req_b[31:0];
  end

  assign bus.o_req_ready = (state_q == S_IDLE && gnt_vld) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_c_d      = rsp_c_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    fpu_start_d  = 1'b0;
    op_count_d   = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          last_grant_d = gnt;
          id_d         = gnt;
          op_d         = req_op_sel;
          a_d          = req_a_sel;
          b_d          = req_b_sel;
          if (OP_MASK[req_op_sel]) begin
            state_d     = S_EXEC;
            cnt_d       = CNT_W'(LATENCY);
            fpu_start_d = 1'b1;
          end else begin
            state_d     = S_RESP;
            rsp_c_d     = NAN_VAL;
            rsp_err_d   = 1'b1;
            rsp_valid_d = gnt ? 2'b10 : 2'b01;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_c_d     = bus.i_fpu_c;
          rsp_err_d   = 1'b0;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready[id_q]) begin
          rsp_valid_d = 2'b00;
          op_count_d  = op_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_c_q      <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 2'b00;
      fpu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_c_q      <= rsp_c_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      fpu_start_q  <= fpu_start_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
    end
  end

  // Operand registers double as the FPU-facing drive, stable for the whole EXEC window
  assign bus.o_fpu_op    = op_q;
  assign bus.o_fpu_a     = a_q;
  assign bus.o_fpu_b     = b_q;
  assign bus.o_fpu_start = fpu_start_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_c     = rsp_c_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_op_count  = op_count_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler with a LATENCY=3 table-driven FPU model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fpu_op_scheduler;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   start_cnt = 0;
  logic st_d1;

  fpu_op_scheduler_if bus ();

  fpu_op_scheduler #(
    .LATENCY(LAT),
    .OP_MASK(16'h0002),
    .NAN_VAL(32'h7FC00000)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40800000_40800000: return 32'h41000000;
      64'h40400000_3F800000: return 32'h40800000;
      64'h3F000000_3F000000: return 32'h3F800000;
      default:               return 32'hBAD0BAD0;
    endcase
  endfunction

  // FPU model: result valid only LAT-1 cycles after the start cycle, garbage otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_d1       <= 1'b0;
      bus.i_fpu_c <= 32'hDEADBEEF;
    end else begin
      st_d1       <= bus.o_fpu_start;
      bus.i_fpu_c <= st_d1 ? fadd(bus.o_fpu_a, bus.o_fpu_b) : 32'hDEADBEEF;
      if (bus.o_fpu_start) start_cnt <= start_cnt + 1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req_valid = 2'b00;
    bus.i_req_op    = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err, bus.o_fpu_start, bus.o_fpu_op,
         bus.o_fpu_a, bus.o_fpu_b, bus.o_busy, bus.o_op_count} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: rsp_valid=%b rsp_c=%h busy=%b count=%0d required all zero",
                        bus.o_rsp_valid, bus.o_rsp_c, bus.o_busy, bus.o_op_count);
    end
    n_cmp++;
    if (bus.o_req_ready !== 2'b00) begin
      n_bad++; $display("FAIL reset_req_ready: got %b required 00", bus.o_req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    bus.i_req_valid = 2'b01;
    bus.i_req_op    = 8'h01;
    bus.i_req_a     = {32'h0, 32'h3F800000};
    bus.i_req_b     = {32'h0, 32'h40000000};
    #1;
    n_cmp++;
    if (bus.o_req_ready !== 2'b01) begin
      n_bad++; $display("FAIL add_accept: req_ready=%b required 01", bus.o_req_ready);
    end
    @(negedge clk); // T+1
    bus.i_req_valid = 2'b00;
    n_cmp++;
    if ({bus.o_fpu_start, bus.o_busy, bus.o_fpu_op, bus.o_fpu_a, bus.o_fpu_b} !==
        {1'b1, 1'b1, 4'h1, 32'h3F800000, 32'h40000000}) begin
      n_bad++; $display("FAIL add_issue: start=%b busy=%b op=%h a=%h b=%h required 1 1 1 3f800000 40000000",
                        bus.o_fpu_start, bus.o_busy, bus.o_fpu_op, bus.o_fpu_a, bus.o_fpu_b);
    end
    @(negedge clk); // T+2
    n_cmp++;
    if (bus.o_fpu_start !== 1'b0) begin
      n_bad++; $display("FAIL add_start_pulse: start=%b at T+2 required 0", bus.o_fpu_start);
    end
    @(negedge clk); // T+3
    n_cmp++;
    if (bus.o_rsp_valid !== 2'b00) begin
      n_bad++; $display("FAIL add_early_rsp: rsp_valid=%b at T+3 required 00", bus.o_rsp_valid);
    end
    @(negedge clk); // T+4
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err} !== {2'b01, 32'h40400000, 1'b0}) begin
      n_bad++; $display("FAIL add_rsp: valid=%b c=%h err=%b required 01 40400000 0",
                        bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err);
    end
    bus.i_rsp_ready = 2'b01;
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_op_count, bus.o_busy} !== {2'b00, 16'd1, 1'b0}) begin
      n_bad++; $display("FAIL add_done: valid=%b count=%0d busy=%b required 00 1 0",
                        bus.o_rsp_valid, bus.o_op_count, bus.o_busy);
    end
  endtask

  task automatic test_contention();
    int w;
    int l;
    logic overlap;
    logic exp_g;
    logic [31:0] exp_c;
    bus.i_req_valid = 2'b11;
    bus.i_req_op    = 8'h11;
    bus.i_req_a     = {32'h40800000, 32'h3F800000};
    bus.i_req_b     = {32'h40800000, 32'h3F800000};
    bus.i_rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0);           // last grant before this test was requester 0
      exp_c = exp_g ? 32'h41000000 : 32'h40000000;
      #1;
      w = 0;
      while (bus.o_req_ready == 2'b00 && w < 20) begin
        @(negedge clk); #1; w++;
      end
      n_cmp++;
      if (bus.o_req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL contention_grant%0d: req_ready=%b required grant %0d", k, bus.o_req_ready, exp_g);
      end
      overlap = 1'b0;
      l = 0;
      do begin
        @(negedge clk); l++;
        if (bus.o_req_ready !== 2'b00) overlap = 1'b1;
      end while (bus.o_rsp_valid == 2'b00 && l < 20);
      n_cmp++;
      if (l != int'(LAT) + 1 || overlap) begin
        n_bad++; $display("FAIL contention_timing%0d: rsp after %0d cycles overlap=%b required %0d 0", k, l, overlap, LAT + 1);
      end
      n_cmp++;
      if ({bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err} !== {(exp_g ? 2'b10 : 2'b01), exp_c, 1'b0}) begin
        n_bad++; $display("FAIL contention_rsp%0d: valid=%b c=%h err=%b required id %0d c=%h err 0",
                          k, bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err, exp_g, exp_c);
      end
      if (k == 7) bus.i_req_valid = 2'b00;
      @(negedge clk);
    end
    bus.i_rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({bus.o_op_count, bus.o_busy} !== {16'd9, 1'b0}) begin
      n_bad++; $display("FAIL contention_count: count=%0d busy=%b required 9 0", bus.o_op_count, bus.o_busy);
    end
  endtask

  task automatic test_unsupported();
    int s0;
    s0 = start_cnt;
    bus.i_req_valid = 2'b10;
    bus.i_req_op    = 8'h70;
    bus.i_req_a     = {32'h3F800000, 32'h0};
    bus.i_req_b     = {32'h3F800000, 32'h0};
    #1;
    n_cmp++;
    if (bus.o_req_ready !== 2'b10) begin
      n_bad++; $display("FAIL unsup_accept: req_ready=%b required 10", bus.o_req_ready);
    end
    @(negedge clk); // T+1
    bus.i_req_valid = 2'b00;
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err, bus.o_fpu_start} !== {2'b10, 32'h7FC00000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL unsup_rsp: valid=%b c=%h err=%b start=%b required 10 7fc00000 1 0",
                        bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err, bus.o_fpu_start);
    end
    bus.i_rsp_ready = 2'b10;
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_op_count} !== {2'b00, 16'd10} || start_cnt != s0) begin
      n_bad++; $display("FAIL unsup_done: valid=%b count=%0d starts=%0d required 00 10 %0d",
                        bus.o_rsp_valid, bus.o_op_count, start_cnt, s0);
    end
  endtask

  task automatic test_backpressure();
    int l;
    logic bad;
    bus.i_req_valid = 2'b01;
    bus.i_req_op    = 8'h11;
    bus.i_req_a     = {32'h3F000000, 32'h40400000};
    bus.i_req_b     = {32'h3F000000, 32'h3F800000};
    #1;
    n_cmp++;
    if (bus.o_req_ready !== 2'b01) begin
      n_bad++; $display("FAIL bp_accept0: req_ready=%b required 01", bus.o_req_ready);
    end
    bad = 1'b0;
    @(negedge clk); // T+1
    bus.i_req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.o_req_ready !== 2'b00) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_rsp_c} !== {2'b01, 32'h40800000}) begin
      n_bad++; $display("FAIL bp_rsp: valid=%b c=%h required 01 40800000", bus.o_rsp_valid, bus.o_rsp_c);
    end
    bus.i_rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      if ({bus.o_rsp_valid, bus.o_rsp_c, bus.o_req_ready} !== {2'b01, 32'h40800000, 2'b00}) bad = 1'b1;
      @(negedge clk);
    end
    bus.i_rsp_ready = 2'b01;
    #1;
    if (bus.o_req_ready !== 2'b00) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL bp_hold: response or ready not held during stall, rsp_c=%h req_ready=%b required 40800000 00",
                        bus.o_rsp_c, bus.o_req_ready);
    end
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    #1;
    n_cmp++;
    if ({bus.o_req_ready, bus.o_op_count} !== {2'b10, 16'd11}) begin
      n_bad++; $display("FAIL bp_accept1: req_ready=%b count=%0d required 10 11", bus.o_req_ready, bus.o_op_count);
    end
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    l = 0;
    while (bus.o_rsp_valid == 2'b00 && l < 20) begin
      @(negedge clk); l++;
    end
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err} !== {2'b10, 32'h3F800000, 1'b0}) begin
      n_bad++; $display("FAIL bp_rsp1: valid=%b c=%h err=%b required 10 3f800000 0",
                        bus.o_rsp_valid, bus.o_rsp_c, bus.o_rsp_err);
    end
    bus.i_rsp_ready = 2'b10;
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    n_cmp++;
    if (bus.o_op_count !== 16'd12) begin
      n_bad++; $display("FAIL bp_count: count=%0d required 12", bus.o_op_count);
    end
  endtask

  task automatic test_reset_mid_exec();
    int l;
    logic seen;
    bus.i_req_valid = 2'b01;
    bus.i_req_op    = 8'h11;
    bus.i_req_a     = {32'h0, 32'h3F800000};
    bus.i_req_b     = {32'h0, 32'h40000000};
    #1;
    n_cmp++;
    if (bus.o_req_ready !== 2'b01) begin
      n_bad++; $display("FAIL rst_exec_accept: req_ready=%b required 01", bus.o_req_ready);
    end
    @(negedge clk); // T+1
    bus.i_req_valid = 2'b00;
    @(negedge clk); // T+2
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_busy, bus.o_rsp_valid, bus.o_op_count, bus.o_fpu_start} !== {1'b0, 2'b00, 16'd0, 1'b0}) begin
      n_bad++; $display("FAIL rst_exec_clear: busy=%b valid=%b count=%0d start=%b required 0 00 0 0",
                        bus.o_busy, bus.o_rsp_valid, bus.o_op_count, bus.o_fpu_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      @(negedge clk);
      if (bus.o_rsp_valid !== 2'b00 || bus.o_busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL rst_exec_abandon: activity after reset, rsp_valid=%b required no response", bus.o_rsp_valid);
    end
    bus.i_req_valid = 2'b11;
    bus.i_req_a     = {32'h40800000, 32'h3F800000};
    bus.i_req_b     = {32'h40800000, 32'h3F800000};
    #1;
    n_cmp++;
    if (bus.o_req_ready !== 2'b01) begin
      n_bad++; $display("FAIL rst_priority: req_ready=%b required 01", bus.o_req_ready);
    end
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    l = 0;
    while (bus.o_rsp_valid == 2'b00 && l < 20) begin
      @(negedge clk); l++;
    end
    n_cmp++;
    if ({bus.o_rsp_valid, bus.o_rsp_c} !== {2'b01, 32'h40000000}) begin
      n_bad++; $display("FAIL rst_after_rsp: valid=%b c=%h required 01 40000000", bus.o_rsp_valid, bus.o_rsp_c);
    end
    bus.i_rsp_ready = 2'b01;
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    n_cmp++;
    if (bus.o_op_count !== 16'd1) begin
      n_bad++; $display("FAIL rst_after_count: count=%0d required 1", bus.o_op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_unsupported();
    test_backpressure();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Shares a single non-pipelined, fixed-latency FPU datapath between two requesters.
- Round-robin arbitration picks the requester. The scheduler latches its operands, pulses the FPU start and waits the configured latency. It captures the result and returns it over a valid/ready response channel to the requester that issued it.
- Opcodes outside the supported mask are rejected with an error response and never reach the FPU.

Parameters:
LATENCY, 3, cycles from o_fpu_start cycle to the cycle i_fpu_c is valid; legal range 1..15
OP_MASK, 16'h0002, bit k set means opcode k is supported by the FPU (default: only 4'b0001 add)
NAN_VAL, 32'h7FC00000, result returned on unsupported opcode

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_req_valid  in  2  per-requester request valid
o_req_ready  out  2  per-requester accept; at most one bit high
i_req_op  in  8  {op1[3:0], op0[3:0]}
i_req_a  in  64  {a1, a0}, 32-bit IEEE-754 single operands
i_req_b  in  64  {b1, b0}
o_rsp_valid  out  2  per-requester response valid; at most one bit high
i_rsp_ready  in  2  per-requester response ready
o_rsp_c  out  32  response data (shared)
o_rsp_err  out  1  response is for an unsupported opcode
o_fpu_start  out  1  one-cycle issue pulse
o_fpu_op  out  4  opcode to FPU, held stable during EXEC
o_fpu_a  out  32  operand A to FPU, held stable during EXEC
o_fpu_b  out  32  operand B to FPU, held stable during EXEC
i_fpu_c  in  32  FPU result
o_busy  out  1  state != IDLE
o_op_count  out  16  completed responses, wraps 16'hFFFF -> 0

Behaviour:
- States: IDLE, EXEC, RESP. All state and outputs are registered, except o_req_ready, which is combinational from state and the arbiter.
- Reset (asynchronous assert, i_reset_n=0):
  - state=IDLE.
  - All outputs 0; o_fpu_op/a/b=0.
  - Internal counter=0. last_grant=1, so requester 0 wins first.
  - Reset mid-EXEC or mid-RESP abandons the op: no response, o_op_count not incremented.
- IDLE:
  - Grant g = the valid requester. If both are valid, g = the requester other than last_grant.
  - o_req_ready[g]=1 only in IDLE; the handshake completes in the same cycle (cycle T).
  - On handshake: latch op/a/b/id=g; last_grant<=g.
  - If OP_MASK[op]=1 -> EXEC, cnt<=LATENCY.
  - Otherwise -> RESP with o_rsp_c<=NAN_VAL and o_rsp_err<=1. o_fpu_start is never asserted for that op.
- EXEC:
  - o_fpu_start=1 only in the first EXEC cycle (T+1). o_fpu_op/a/b are driven from the latched values for all of EXEC.
  - cnt decrements each EXEC cycle.
  - In the cycle cnt==1 (cycle T+LATENCY... counting from T+1 this is T+LATENCY), i_fpu_c is sampled into o_rsp_c, o_rsp_err<=0, state -> RESP.
  - Equivalently, i_fpu_c must be valid LATENCY-1 cycles after the start cycle.
  - With LATENCY=1, the result is sampled in the start cycle itself.
- RESP:
  - o_rsp_valid[id]=1; o_rsp_c and o_rsp_err are held until i_rsp_ready[id]=1.
  - i_rsp_ready on the other port is ignored.
  - On completion: o_rsp_valid<=0, o_op_count<=o_op_count+1, state -> IDLE.
  - o_req_ready=0 throughout RESP. A request valid in the completion cycle is accepted no earlier than the next (IDLE) cycle.
- Latency:
  - Supported op: accept at T -> o_rsp_valid at T+LATENCY+1. Minimum turnaround is LATENCY+2 cycles per op under full pressure.
  - Unsupported op: accept at T -> o_rsp_valid at T+1.
- Requester rules: i_req_op/a/b need only be stable in the handshake cycle. Dropping valid before the grant is permitted and nothing is issued.
- o_busy=0 only in IDLE.

Test Plan:
- Reset: assert i_reset_n=0 mid-stream -> all outputs 0, o_req_ready=2'b00 until valid is asserted.
- Single add, LATENCY=3: req0 valid, op=1, a=32'h3F800000, b=32'h40000000 accepted at T. Expect:
  - o_fpu_start=1 only at T+1.
  - FPU model drives 32'h40400000 at T+3.
  - o_rsp_valid=2'b01 at T+4, o_rsp_c=32'h40400000, o_rsp_err=0.
  - o_op_count=1 after the ready handshake.
- Contention: both requesters hold valid for 4 ops each -> grants alternate 0,1,0,1,...; each o_rsp_valid goes only to the issuer; no overlap between ops.
- Unsupported op: req1 op=4'b0111 accepted at T -> no o_fpu_start; o_rsp_valid=2'b10 at T+1, o_rsp_c=32'h7FC00000, o_rsp_err=1.
- Backpressure: i_rsp_ready[0]=0 for 5 cycles while in RESP, with req1 valid -> o_rsp_c held and o_req_ready=0 throughout; req1 is accepted the cycle after the response handshake.
- Reset mid-EXEC: pulse i_reset_n low at T+2 -> no response, o_op_count unchanged. After release, requester 0 has priority when both are valid.
